pe_mac_sequencer: RTL and testbench

- Sequences a single signed multiply-accumulate processing element (PE) through a dot product of length L.
- Fetches x/w operand pairs from an external 1-cycle-latency operand buffer and issues them to the PE.
- Feeds the running partial sum back to the PE's psum input, saturating BW2-wide PE results to BW1 before feedback.
- Returns the final sum through a valid/ready handshake. Sits between the operand buffers and one PE instance.

---
 rtl/pe_mac_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pe_mac_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_sequencer.sv
// Sequences one signed MAC processing element through a length-L dot product,
// saturating each PE result to BW1 before feeding it back as the next psum.
module pe_mac_sequencer #(
    parameter int unsigned XW     = 8,
    parameter int unsigned WW     = 8,
    parameter int unsigned BW1    = 16,
    parameter int unsigned BW2    = 17,
    parameter int unsigned LW     = 8,
    parameter int unsigned AW     = 8,
    parameter int unsigned PE_LAT = 1
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [LW-1:0]  i_len,
    input  logic [BW1-1:0] i_bias,
    output logic           o_busy,
    output logic           o_rd_en,
    output logic [AW-1:0]  o_addr,
    input  logic [XW-1:0]  i_x,
    input  logic [WW-1:0]  i_w,
    output logic [XW-1:0]  o_pe_x,
    output logic [WW-1:0]  o_pe_w,
    output logic [BW1-1:0] o_pe_psum,
    input  logic [BW2-1:0] i_pe_psum,
    output logic [BW1-1:0] o_result,
    output logic           o_valid,
    input  logic           i_ready,
    output logic           o_sat
);

    localparam int unsigned CW = (PE_LAT < 1) ? 1 : $clog2(PE_LAT + 1);

    // BW1 signed limits, sign-extended to the PE output width for comparison
    localparam logic [BW2-1:0] SatHi = {{(BW2 - BW1 + 1){1'b0}}, {(BW1 - 1){1'b1}}};
    localparam logic [BW2-1:0] SatLo = {{(BW2 - BW1 + 1){1'b1}}, {(BW1 - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StRead, StLoad, StWait, StDone} state_e;

    state_e         state_q, state_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW1-1:0] acc_q, acc_d;
    logic [XW-1:0]  pe_x_q, pe_x_d;
    logic [WW-1:0]  pe_w_q, pe_w_d;
    logic [BW1-1:0] pe_psum_q, pe_psum_d;
    logic [BW1-1:0] result_q, result_d;
    logic           sat_q, sat_d;

    logic           over, under;
    logic [BW1-1:0] sat_val;

    always_comb begin
        over    = $signed(i_pe_psum) > $signed(SatHi);
        under   = $signed(i_pe_psum) < $signed(SatLo);
        sat_val = i_pe_psum[BW1-1:0];
        if (over) begin
            sat_val = SatHi[BW1-1:0];
        end else if (under) begin
            sat_val = SatLo[BW1-1:0];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            len_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            pe_x_q    <= '0;
            pe_w_q    <= '0;
            pe_psum_q <= '0;
            result_q  <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            pe_x_q    <= pe_x_d;
            pe_w_q    <= pe_w_d;
            pe_psum_q <= pe_psum_d;
            result_q  <= result_d;
            sat_q     <= sat_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        pe_x_d    = pe_x_q;
        pe_w_d    = pe_w_q;
        pe_psum_d = pe_psum_q;
        result_d  = result_q;
        sat_d     = sat_q;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    len_d = i_len;
                    acc_d = i_bias;
                    idx_d = '0;
                    sat_d = 1'b0;
                    if (i_len == '0) begin
                        result_d = i_bias;
                        state_d  = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                state_d = StLoad;
            end
            StLoad: begin
                pe_x_d    = i_x;
                pe_w_d    = i_w;
                pe_psum_d = acc_q;
                cnt_d     = '0;
                state_d   = StWait;
            end
            StWait: begin
                if (cnt_q == CW'(PE_LAT)) begin
                    acc_d = sat_val;
                    if (over || under) begin
                        sat_d = 1'b1;
                    end
                    idx_d = idx_q + LW'(1);
                    if (idx_q == len_q - LW'(1)) begin
                        result_d = sat_val;
                        state_d  = StDone;
                    end else begin
                        state_d = StRead;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (i_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign o_busy    = (state_q != StIdle);
    assign o_rd_en   = (state_q == StRead);
    assign o_addr    = (state_q == StRead) ? AW'(idx_q) : '0;
    assign o_pe_x    = pe_x_q;
    assign o_pe_w    = pe_w_q;
    assign o_pe_psum = pe_psum_q;
    assign o_result  = result_q;
    assign o_valid   = (state_q == StDone);
    assign o_sat     = sat_q;

endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed bench for pe_mac_sequencer with a 1-cycle operand buffer and a
// registered MAC PE model (PE_LAT = 1).
module tb_pe_mac_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [7:0]         len;
    logic [15:0]        bias;
    logic               busy, rd_en, valid, ready, sat;
    logic [7:0]         addr;
    logic [7:0]         x_in, w_in, pe_x, pe_w;
    logic [15:0]        pe_psum, result;
    logic [16:0]        pe_out;

    logic signed [7:0]  mem_x [4];
    logic signed [7:0]  mem_w [4];

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cyc [8];
    int rd_addr [8];
    int vcyc, nrd;

    always #5 clk = ~clk;

    pe_mac_sequencer dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_len     (len),
        .i_bias    (bias),
        .o_busy    (busy),
        .o_rd_en   (rd_en),
        .o_addr    (addr),
        .i_x       (x_in),
        .i_w       (w_in),
        .o_pe_x    (pe_x),
        .o_pe_w    (pe_w),
        .o_pe_psum (pe_psum),
        .i_pe_psum (pe_out),
        .o_result  (result),
        .o_valid   (valid),
        .i_ready   (ready),
        .o_sat     (sat)
    );

    // Operand buffer: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            x_in <= mem_x[addr[1:0]];
            w_in <= mem_w[addr[1:0]];
        end
    end

    // Registered MAC PE: psum + x*w, one cycle after its inputs
    logic signed [16:0] xe, we, pe_sum;
    logic signed [15:0] ps16;
    always_comb begin
        xe     = $signed(pe_x);
        we     = $signed(pe_w);
        ps16   = $signed(pe_psum);
        pe_sum = 17'(ps16) + xe * we;
    end
    always @(posedge clk) pe_out <= pe_sum;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input int x0, input int w0, input int x1, input int w1,
                            input int x2, input int w2);
        mem_x[0] = 8'(x0); mem_w[0] = 8'(w0);
        mem_x[1] = 8'(x1); mem_w[1] = 8'(w1);
        mem_x[2] = 8'(x2); mem_w[2] = 8'(w2);
        mem_x[3] = '0;     mem_w[3] = '0;
    endtask

    // Start a job at cycle 0; return the cycle o_valid first rises (-1 on timeout)
    task automatic run_job(input int b, input int l, output int vc, output int nr);
        bias  = 16'(b);
        len   = 8'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
        vc = -1;
        nr = 0;
        for (int c = 1; c < 200; c++) begin
            if (valid) begin
                vc = c;
                break;
            end
            if (rd_en) begin
                if (nr < 8) begin
                    rd_cyc[nr]  = c;
                    rd_addr[nr] = int'(addr);
                end
                nr++;
            end
            tick();
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        bias  = '0;
        ready = 1'b1;
        x_in  = '0;
        w_in  = '0;
        load_mem(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", valid, 0);
        check("rst_result", $signed(result), 0);
        check("rst_sat", sat, 0);
        check("rst_pe_psum", $signed(pe_psum), 0);

        // Basic dot product: 100 + 5000 + 50 + 400
        load_mem(100, 50, 10, 5, 80, 5);
        run_job(100, 3, vcyc, nrd);
        check("j1_valid_cycle", vcyc, 13);
        check("j1_result", $signed(result), 5550);
        check("j1_sat", sat, 0);
        check("j1_nrd", nrd, 3);
        check("j1_rd0_cyc", rd_cyc[0], 1);
        check("j1_rd1_cyc", rd_cyc[1], 5);
        check("j1_rd2_cyc", rd_cyc[2], 9);
        check("j1_rd0_addr", rd_addr[0], 0);
        check("j1_rd1_addr", rd_addr[1], 1);
        check("j1_rd2_addr", rd_addr[2], 2);
        check("j1_pe_x_held", $signed(pe_x), 80);
        tick();
        check("j1_idle_busy", busy, 0);

        // Positive saturation on the last element
        load_mem(127, 127, 127, 127, 127, 127);
        run_job(0, 3, vcyc, nrd);
        check("j2_result", $signed(result), 32767);
        check("j2_sat", sat, 1);
        tick();

        // Negative saturation, then sticky flag cleared by the next job
        load_mem(-128, 127, -128, 127, -128, 127);
        run_job(0, 3, vcyc, nrd);
        check("j3_result", $signed(result), -32768);
        check("j3_sat", sat, 1);
        tick();
        load_mem(1, 1, 0, 0, 0, 0);
        run_job(5, 1, vcyc, nrd);
        check("j4_valid_cycle", vcyc, 5);
        check("j4_result", $signed(result), 6);
        check("j4_sat", sat, 0);
        tick();

        // Zero-length job returns the bias directly
        run_job(-7, 0, vcyc, nrd);
        check("j5_valid_cycle", vcyc, 1);
        check("j5_result", $signed(result), -7);
        check("j5_nrd", nrd, 0);
        tick();

        // Back-pressure in DONE with an ignored start pulse
        ready = 1'b0;
        load_mem(2, 3, 0, 0, 0, 0);
        run_job(0, 1, vcyc, nrd);
        check("j6_valid_cycle", vcyc, 5);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) begin
                start = 1'b1;
                len   = 8'd2;
                bias  = 16'd999;
            end
            tick();
            start = 1'b0;
            check("j6_hold_valid", valid, 1);
            check("j6_hold_result", $signed(result), 6);
        end
        ready = 1'b1;
        tick();
        check("j6_release_valid", valid, 0);
        check("j6_release_busy", busy, 0);
        run_job(1, 1, vcyc, nrd);
        check("j7_valid_cycle", vcyc, 5);
        check("j7_result", $signed(result), 7);
        tick();

        // Reset during the WAIT of element 1 (cycle 7)
        load_mem(100, 50, 10, 5, 80, 5);
        bias  = 16'd100;
        len   = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        check("r_pre_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("r_busy", busy, 0);
        check("r_rd_en", rd_en, 0);
        check("r_addr", addr, 0);
        check("r_valid", valid, 0);
        check("r_sat", sat, 0);
        check("r_result", $signed(result), 0);
        check("r_pe_x", pe_x, 0);
        check("r_pe_w", pe_w, 0);
        check("r_pe_psum", $signed(pe_psum), 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("r_stays_idle", busy, 0);
        end
        run_job(100, 3, vcyc, nrd);
        check("r_job_valid_cycle", vcyc, 13);
        check("r_job_result", $signed(result), 5550);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
